// File: rtl/alu_pipe.sv
// alu_pipe: single-stage pipelined ALU with an internal accumulator and a
// valid/ready handshake on both sides.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - A, B and sel are presented this cycle
//   in_ready   - combinational: a transfer is accepted this cycle
//   A, B       - WIDTH-bit operands
//   sel        - 4-bit opcode
//   X          - registered WIDTH-bit result
//   flags      - registered {ovf, carry, zero}
//   out_valid  - X/flags hold an unconsumed result
//   out_ready  - consumer takes the result this cycle
//
// Build option: define ALU_SATURATE_EN to clamp add-type ops to all-ones on
// carry-out and subtract-type ops to zero on borrow. Without it, results wrap.
module alu_pipe #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] X,
  output logic [2:0]       flags,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_ZERO = 4'b0000;
  localparam logic [3:0] OP_A    = 4'b0001;
  localparam logic [3:0] OP_B    = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_INC  = 4'b1011;
  localparam logic [3:0] OP_DEC  = 4'b1100;
  localparam logic [3:0] OP_AADD = 4'b1101;
  localparam logic [3:0] OP_ACLR = 4'b1110;
  localparam logic [3:0] OP_ARD  = 4'b1111;

  logic [WIDTH-1:0] acc;

  logic             accept_c;
  logic [WIDTH-1:0] add_a_c, add_b_c, sub_a_c, sub_b_c;
  logic [WIDTH:0]   sum_c, diff_c;
  logic             add_ovf_c, sub_ovf_c;
  logic [WIDTH-1:0] add_res_c, sub_res_c;
  logic [WIDTH-1:0] res_c, acc_nxt_c;
  logic             carry_c, ovf_c;

  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;

  // Operand steering for the shared adder and subtractor
  always_comb begin
    add_a_c = A;
    add_b_c = B;
    sub_a_c = A;
    sub_b_c = B;
    if (sel == OP_INC) add_b_c = WIDTH'(1);
    if (sel == OP_AADD) begin
      add_a_c = acc;
      add_b_c = A;
    end
    if (sel == OP_DEC) sub_b_c = WIDTH'(1);
  end

  // Extra top bit carries the unsigned carry-out / borrow
  assign sum_c  = {1'b0, add_a_c} + {1'b0, add_b_c};
  assign diff_c = {1'b0, sub_a_c} - {1'b0, sub_b_c};

  // Signed overflow: like-signed add or unlike-signed subtract flipping sign
  assign add_ovf_c = (add_a_c[MSB] == add_b_c[MSB]) && (sum_c[MSB]  != add_a_c[MSB]);
  assign sub_ovf_c = (sub_a_c[MSB] != sub_b_c[MSB]) && (diff_c[MSB] != sub_a_c[MSB]);

`ifdef ALU_SATURATE_EN
  assign add_res_c = sum_c[WIDTH]  ? {WIDTH{1'b1}} : sum_c[WIDTH-1:0];
  assign sub_res_c = diff_c[WIDTH] ? {WIDTH{1'b0}} : diff_c[WIDTH-1:0];
`else
  assign add_res_c = sum_c[WIDTH-1:0];
  assign sub_res_c = diff_c[WIDTH-1:0];
`endif

  // Result, raw carry/overflow and next accumulator per opcode
  always_comb begin
    res_c     = '0;
    carry_c   = 1'b0;
    ovf_c     = 1'b0;
    acc_nxt_c = acc;
    unique case (sel)
      OP_ZERO: res_c = '0;
      OP_A:    res_c = A;
      OP_B:    res_c = B;
      OP_ADD, OP_INC: begin
        res_c   = add_res_c;
        carry_c = sum_c[WIDTH];
        ovf_c   = add_ovf_c;
      end
      OP_SUB, OP_DEC: begin
        res_c   = sub_res_c;
        carry_c = diff_c[WIDTH];
        ovf_c   = sub_ovf_c;
      end
      OP_AND:  res_c = A & B;
      OP_OR:   res_c = A | B;
      OP_XOR:  res_c = A ^ B;
      OP_NOT:  res_c = ~A;
      OP_SHL: begin
        res_c   = {A[MSB-1:0], 1'b0};
        carry_c = A[MSB];
      end
      OP_SHR: begin
        res_c   = {1'b0, A[MSB:1]};
        carry_c = A[0];
      end
      OP_AADD: begin
        res_c     = add_res_c;
        carry_c   = sum_c[WIDTH];
        ovf_c     = add_ovf_c;
        acc_nxt_c = add_res_c;
      end
      OP_ACLR: begin
        res_c     = '0;
        acc_nxt_c = '0;
      end
      OP_ARD:  res_c = acc;
      default: res_c = '0;
    endcase
  end

  // Output stage and accumulator; held unless a transfer is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      X         <= '0;
      flags     <= 3'b000;
      out_valid <= 1'b0;
      acc       <= '0;
    end else if (accept_c) begin
      X         <= res_c;
      flags     <= {ovf_c, carry_c, (res_c == '0)};
      out_valid <= 1'b1;
      acc       <= acc_nxt_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH=6). Directed cases
// followed by randomized traffic, all checked against an integer-arithmetic
// reference model of the ALU, accumulator and output handshake.
module tb_alu_pipe;

  localparam int W    = 6;
  localparam int MOD  = 1 << W;
  localparam int HALF = MOD / 2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   sel;
  logic [W-1:0] x;
  logic [2:0]   flags;
  logic         out_valid;
  logic         out_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_x     = 0;
  int m_flags = 0;
  int m_acc   = 0;
  bit m_valid = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .sel       (sel),
    .X         (x),
    .flags     (flags),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= HALF) ? v - MOD : v;
  endfunction

  function automatic void ref_add(input int p, input int q, output int r, output bit cy, output bit ov);
    int s;
    int ss;
    s  = p + q;
    ss = sgn(p) + sgn(q);
    cy = (s >= MOD);
    ov = (ss < -HALF) || (ss > HALF - 1);
    r  = s % MOD;
`ifdef ALU_SATURATE_EN
    if (cy) r = MOD - 1;
`endif
  endfunction

  function automatic void ref_sub(input int p, input int q, output int r, output bit cy, output bit ov);
    int s;
    int ss;
    s  = p - q;
    ss = sgn(p) - sgn(q);
    cy = (s < 0);
    ov = (ss < -HALF) || (ss > HALF - 1);
    r  = (s + MOD) % MOD;
`ifdef ALU_SATURATE_EN
    if (cy) r = 0;
`endif
  endfunction

  // One opcode on integer operands: result, {ovf,carry,zero}, next accumulator
  function automatic void ref_op(input int av, input int bv, input int s, input int acc_in,
                                 output int r, output int fl, output int acc_out);
    bit cy;
    bit ov;
    cy      = 0;
    ov      = 0;
    r       = 0;
    acc_out = acc_in;
    case (s)
      0:  r = 0;
      1:  r = av;
      2:  r = bv;
      3:  ref_add(av, bv, r, cy, ov);
      4:  ref_sub(av, bv, r, cy, ov);
      5:  r = av & bv;
      6:  r = av | bv;
      7:  r = av ^ bv;
      8:  r = (MOD - 1) - av;
      9:  begin r = (av * 2) % MOD; cy = (av >= HALF); end
      10: begin r = av / 2; cy = (av % 2) == 1; end
      11: ref_add(av, 1, r, cy, ov);
      12: ref_sub(av, 1, r, cy, ov);
      13: begin ref_add(acc_in, av, r, cy, ov); acc_out = r; end
      14: begin r = 0; acc_out = 0; end
      default: r = acc_in;
    endcase
    fl = {29'd0, ov, cy, (r == 0)};
  endfunction

  // Drive one cycle of stimulus, step the model at the edge, compare after it
  task automatic cycle(input bit iv, input int av, input int bv, input int sv, input bit ordy);
    bit acc_now;
    int r;
    int fl;
    int na;
    in_valid  = iv;
    a         = W'(av);
    b         = W'(bv);
    sel       = 4'(sv);
    out_ready = ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
    acc_now = iv && (!m_valid || ordy);
    @(posedge clk);
    if (acc_now) begin
      ref_op(av % MOD, bv % MOD, sv % 16, m_acc, r, fl, na);
      m_x     = r;
      m_flags = fl;
      m_acc   = na;
      m_valid = 1;
    end else if (ordy) begin
      m_valid = 0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("X", 32'(x), 32'(m_x));
    check("flags", 32'(flags), 32'(m_flags));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sel       = '0;

    // Reset state, in_ready held high during reset
    #3;
    check("rst_X", 32'(x), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #9;
    rst_n = 1'b1;

    // 4 + 2
    cycle(1, 4, 2, 3, 1);
    check("add_X", 32'(x), 32'd6);
    check("add_flags", 32'(flags), 32'b000);
    check("add_valid", 32'(out_valid), 32'd1);

    // 63 + 1: carry out
    cycle(1, 63, 1, 3, 1);
`ifdef ALU_SATURATE_EN
    check("carry_X", 32'(x), 32'd63);
    check("carry_flags", 32'(flags), 32'b010);
`else
    check("carry_X", 32'(x), 32'd0);
    check("carry_flags", 32'(flags), 32'b011);
`endif

    // 31 + 1: signed overflow
    cycle(1, 31, 1, 3, 1);
    check("ovf_X", 32'(x), 32'd32);
    check("ovf_flags", 32'(flags), 32'b100);

    // 2 - 4: borrow
    cycle(1, 2, 4, 4, 1);
`ifdef ALU_SATURATE_EN
    check("borrow_X", 32'(x), 32'd0);
    check("borrow_flags", 32'(flags), 32'b011);
`else
    check("borrow_X", 32'(x), 32'd62);
    check("borrow_carry", 32'(flags[1]), 32'd1);
`endif

    // Accumulator: clear, add 5 twice, read
    cycle(1, 9, 9, 14, 1);
    check("acc_clr", 32'(x), 32'd0);
    cycle(1, 5, 0, 13, 1);
    check("acc_add1", 32'(x), 32'd5);
    cycle(1, 5, 0, 13, 1);
    check("acc_add2", 32'(x), 32'd10);
    cycle(1, 0, 0, 15, 1);
    check("acc_rd", 32'(x), 32'd10);

    // Backpressure: inputs toggle but nothing is accepted
    for (int i = 0; i < 5; i++) begin
      cycle(1, (i % 2) ? 63 : 1, i, (i % 2) ? 13 : 14, 0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_X", 32'(x), 32'd10);
    end
    // Consume and accept on the same edge; acc must still be 10
    cycle(1, 3, 0, 15, 1);
    check("bp_release_X", 32'(x), 32'd10);
    check("bp_release_valid", 32'(out_valid), 32'd1);
    cycle(0, 0, 0, 0, 0);

    // Asynchronous reset mid-cycle with a pending result and acc=10
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_X", 32'(x), 32'd0);
    check("arst_flags", 32'(flags), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    m_x     = 0;
    m_flags = 0;
    m_acc   = 0;
    m_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 0, 15, 1);
    check("arst_acc", 32'(x), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), int'($urandom_range(0, MOD - 1)),
            int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 6, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operands and sel presented this cycle.
REQ-005 SHALL have port in_ready  output  1  block accepts a transfer this cycle.
REQ-006 SHALL have port A  input  WIDTH  operand A.
REQ-007 SHALL have port B  input  WIDTH  operand B.
REQ-008 SHALL have port sel  input  4  opcode.
REQ-009 SHALL have port X  output  WIDTH  registered result.
REQ-010 SHALL have port flags  output  3  registered {ovf, carry, zero}.
REQ-011 SHALL have port out_valid  output  1  X/flags hold an unconsumed result.
REQ-012 SHALL have port out_ready  input  1  consumer takes result this cycle.

Function
REQ-013 SHALL accept a transfer when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational, no other path).
REQ-014 SHALL register X, flags and out_valid=1 on the edge of acceptance: latency exactly 1 cycle, throughput 1 per cycle under continuous out_ready.
REQ-015 SHALL clear out_valid when out_ready && out_valid and no new acceptance occurs that edge; simultaneous consume+accept keeps out_valid=1 with new data.
REQ-016 SHALL hold X, flags and the accumulator stable while out_valid && !out_ready (backpressure); A/B/sel ignored when not accepted.
REQ-017 SHALL implement sel: 0000 X=0; 0001 A; 0010 B; 0011 A+B; 0100 A-B; 0101 A&B; 0110 A|B; 0111 A^B; 1000 ~A; 1001 A<<1; 1010 A>>1 logical; 1011 A+1; 1100 A-1; 1101 ACC_ADD; 1110 ACC_CLR; 1111 ACC_RD.
REQ-018 SHALL keep a WIDTH-bit accumulator: ACC_ADD sets acc and X to acc+A; ACC_CLR sets acc and X to 0; ACC_RD sets X=acc, acc unchanged; other opcodes leave acc unchanged.
REQ-019 SHALL compute all arithmetic modulo 2^WIDTH (wrap-around), truncating to WIDTH.
REQ-020 SHALL set carry = unsigned carry-out for add-type ops (0011, 1011, 1101), borrow (1 when minuend < subtrahend unsigned) for 0100/1100, bit shifted out for 1001/1010, 0 otherwise.
REQ-021 SHALL set ovf = two's-complement signed overflow for 0011, 0100, 1011, 1100, 1101; 0 otherwise.
REQ-022 SHALL set zero = (X == 0) on the final registered X for every opcode.

Reset
REQ-023 SHALL on rst_n low immediately force X=0, flags=000, out_valid=0, acc=0, regardless of clock, including mid-backpressure; in-flight result discarded.
REQ-024 SHALL keep in_ready=1 during and after reset (out_valid=0); first acceptance on first rising edge with rst_n high.

Configuration
REQ-025 SHALL, with macro ALU_SATURATE_EN defined, clamp 0011, 1011, 1101 to all-ones on unsigned carry and 0100, 1100 to 0 on borrow (acc receives clamped value); carry/ovf report the raw unclamped condition; zero reflects clamped X.
REQ-026 SHALL, without ALU_SATURATE_EN, wrap as REQ-019 with no saturation logic present.

Verification (WIDTH=6)
REQ-027 SHALL check: A=000100,B=000010,sel=0011,out_ready=1 -> next cycle X=000110, flags=000, out_valid=1.
REQ-028 SHALL check: A=111111,B=000001,sel=0011 -> X=000000, flags=011 (carry, zero) without macro; X=111111, flags=010 with ALU_SATURATE_EN.
REQ-029 SHALL check: A=011111,B=000001,sel=0011 -> X=100000, flags=100 (ovf); A=000010,B=000100,sel=0100 -> X=111110, carry=1 (saturated build X=000000, flags=011).
REQ-030 SHALL check: ACC_CLR then ACC_ADD A=000101 twice then ACC_RD -> X sequence 0, 000101, 001010, 001010.
REQ-031 SHALL check backpressure: out_ready=0 with out_valid=1 -> in_ready=0, X/acc held across 5 cycles while A/sel toggle; out_ready=1 with in_valid=1 -> consume and accept same edge, out_valid stays 1.
REQ-032 SHALL check: rst_n pulled low asynchronously mid-cycle with out_valid=1, acc=001010 -> X=0, flags=000, out_valid=0, acc=0 before next clock edge.
